// File: rtl/ysyx_axi4_sram_responder_if.sv
// AXI4 read/write channel bundle between the core's io_master_* port and a subordinate.
interface ysyx_axi4_sram_responder_if #(
  parameter int unsigned ADDR_W = 32
);
  logic [ADDR_W-1:0] araddr;
  logic [3:0]        arid;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;

  logic [63:0]       rdata;
  logic [1:0]        rresp;
  logic [3:0]        rid;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  logic [ADDR_W-1:0] awaddr;
  logic [3:0]        awid;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awvalid;
  logic              awready;

  logic [63:0]       wdata;
  logic [7:0]        wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;

  logic [1:0]        bresp;
  logic [3:0]        bid;
  logic              bvalid;
  logic              bready;

  modport slave (
    input  araddr, arid, arlen, arsize, arburst, arvalid,
    output arready,
    output rdata, rresp, rid, rlast, rvalid,
    input  rready,
    input  awaddr, awid, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bid, bvalid,
    input  bready
  );

  modport master (
    output araddr, arid, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rdata, rresp, rid, rlast, rvalid,
    output rready,
    output awaddr, awid, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bid, bvalid,
    output bready
  );
endinterface

// File: rtl/ysyx_axi4_sram_responder.sv
// AXI4 subordinate backed by a 64-bit word array: INCR/FIXED read bursts, single-beat writes,
// one outstanding transaction per direction with a programmable access latency.
module ysyx_axi4_sram_responder #(
  parameter int unsigned       ADDR_W  = 32,
  parameter int unsigned       DEPTH   = 4096,
  parameter logic [ADDR_W-1:0] BASE    = 'h8000_0000,
  parameter int unsigned       LATENCY = 2
) (
  input logic                       clk,
  input logic                       rst,
  ysyx_axi4_sram_responder_if.slave bus
);
  localparam int unsigned       IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] SPAN  = ADDR_W'(DEPTH * 8);
  localparam logic [3:0]        LAT   = 4'(LATENCY);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BEAT} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wr_state_t;

  logic [63:0] mem [DEPTH];

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (a >= BASE) && ((a - BASE) < SPAN);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'((a - BASE) >> 3);
  endfunction

  rd_state_t         rd_state;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_len;
  logic [7:0]        rd_beat;
  logic [2:0]        rd_size;
  logic              rd_incr;
  logic [3:0]        rd_wait;
  logic [63:0]       rdata_q;
  logic [1:0]        rresp_q;
  logic [3:0]        rid_q;
  logic              rlast_q;
  logic              rvalid_q;

  assign bus.arready = (rd_state == R_IDLE) && !rst;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;
  assign bus.rid     = rid_q;
  assign bus.rlast   = rlast_q;
  assign bus.rvalid  = rvalid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state <= R_IDLE;
      rd_addr  <= '0;
      rd_len   <= '0;
      rd_beat  <= '0;
      rd_size  <= '0;
      rd_incr  <= 1'b0;
      rd_wait  <= '0;
      rdata_q  <= '0;
      rresp_q  <= '0;
      rid_q    <= '0;
      rlast_q  <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      unique case (rd_state)
        R_IDLE: if (bus.arvalid) begin
          rd_addr  <= bus.araddr;
          rid_q    <= bus.arid;
          rd_len   <= bus.arlen;
          rd_size  <= bus.arsize;
          rd_incr  <= (bus.arburst == 2'b01);
          rd_beat  <= '0;
          rd_wait  <= LAT;
          rd_state <= R_WAIT;
        end
        R_WAIT: if (rd_wait == '0) begin
          // Each beat is decoded on its own, so a burst may walk off the end of the array.
          if (in_range(rd_addr)) begin
            rdata_q <= mem[word_idx(rd_addr)];
            rresp_q <= 2'b00;
          end else begin
            rdata_q <= '0;
            rresp_q <= 2'b11;
          end
          rlast_q  <= (rd_beat == rd_len);
          rvalid_q <= 1'b1;
          rd_state <= R_BEAT;
        end else begin
          rd_wait <= rd_wait - 4'd1;
        end
        R_BEAT: if (bus.rready) begin
          rvalid_q <= 1'b0;
          if (rlast_q) begin
            rd_state <= R_IDLE;
          end else begin
            if (rd_incr) rd_addr <= rd_addr + (ADDR_W'(1) << rd_size);
            rd_beat  <= rd_beat + 8'd1;
            rd_wait  <= LAT;
            rd_state <= R_WAIT;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  wr_state_t         wr_state;
  logic              aw_cap;
  logic              w_cap;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_len;
  logic [3:0]        wr_id;
  logic [63:0]       wr_data;
  logic [7:0]        wr_strb;
  logic [3:0]        wr_wait;
  logic [1:0]        bresp_q;
  logic [3:0]        bid_q;
  logic              bvalid_q;
  logic              commit;
  logic              unused_inputs;

  assign bus.awready = (wr_state == W_IDLE) && !aw_cap && !rst;
  assign bus.wready  = (wr_state == W_IDLE) && !w_cap && !rst;
  assign bus.bresp   = bresp_q;
  assign bus.bid     = bid_q;
  assign bus.bvalid  = bvalid_q;
  assign unused_inputs = ^{bus.awsize, bus.awburst, bus.wlast};

  assign commit = !rst && (wr_state == W_WAIT) && (wr_wait == '0)
                  && in_range(wr_addr) && (wr_len == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state <= W_IDLE;
      aw_cap   <= 1'b0;
      w_cap    <= 1'b0;
      wr_addr  <= '0;
      wr_len   <= '0;
      wr_id    <= '0;
      wr_data  <= '0;
      wr_strb  <= '0;
      wr_wait  <= '0;
      bresp_q  <= '0;
      bid_q    <= '0;
      bvalid_q <= 1'b0;
    end else begin
      unique case (wr_state)
        W_IDLE: begin
          if (bus.awvalid && !aw_cap) begin
            aw_cap  <= 1'b1;
            wr_addr <= bus.awaddr;
            wr_len  <= bus.awlen;
            wr_id   <= bus.awid;
          end
          if (bus.wvalid && !w_cap) begin
            w_cap   <= 1'b1;
            wr_data <= bus.wdata;
            wr_strb <= bus.wstrb;
          end
          // Advance as soon as both halves are held or arriving this cycle, in either order.
          if ((aw_cap || bus.awvalid) && (w_cap || bus.wvalid)) begin
            wr_wait  <= LAT;
            wr_state <= W_WAIT;
          end
        end
        W_WAIT: if (wr_wait == '0) begin
          if (!in_range(wr_addr))   bresp_q <= 2'b11;
          else if (wr_len != '0)    bresp_q <= 2'b10;
          else                      bresp_q <= 2'b00;
          bid_q    <= wr_id;
          bvalid_q <= 1'b1;
          wr_state <= W_RESP;
        end else begin
          wr_wait <= wr_wait - 4'd1;
        end
        W_RESP: if (bus.bready) begin
          bvalid_q <= 1'b0;
          aw_cap   <= 1'b0;
          w_cap    <= 1'b0;
          wr_state <= W_IDLE;
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  // Array has no reset; a read sampled alongside a commit sees the pre-commit word.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (wr_strb[i]) mem[word_idx(wr_addr)][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_ysyx_axi4_sram_responder.sv
// Directed plus randomized bench for ysyx_axi4_sram_responder against a word-map reference model.
module tb_ysyx_axi4_sram_responder;
  localparam int unsigned LAT     = 2;
  localparam longint      BASE_L  = 64'h8000_0000;
  localparam longint      DEPTH_L = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ysyx_axi4_sram_responder_if #(.ADDR_W(32)) bus ();

  ysyx_axi4_sram_responder #(
    .ADDR_W(32), .DEPTH(4096), .BASE(32'h8000_0000), .LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [63:0] ref_mem [longint];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic in_rng(input logic [31:0] a);
    longint al = longint'({32'h0, a});
    return (al >= BASE_L) && (al < BASE_L + DEPTH_L * 8);
  endfunction

  function automatic logic [63:0] ref_word(input logic [31:0] a);
    longint w = (longint'({32'h0, a}) - BASE_L) / 8;
    if (!in_rng(a)) return 64'h0;
    return ref_mem.exists(w) ? ref_mem[w] : 64'h0;
  endfunction

  task automatic do_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                          input logic [7:0] len, input logic [3:0] id,
                          input int unsigned w_start, input int unsigned aw_start);
    bit aw_pend = 1'b1, w_pend = 1'b1, aw_hs, w_hs;
    int unsigned cyc = 0, n = 0;
    logic [1:0]  exp_resp;
    logic [63:0] word;
    longint      w;
    bus.awaddr = a; bus.awid = id; bus.awlen = len; bus.awsize = 3'd3; bus.awburst = 2'b01;
    bus.wdata = d; bus.wstrb = s; bus.wlast = 1'b1;
    while ((aw_pend || w_pend) && cyc < 40) begin
      bus.awvalid = aw_pend && (cyc >= aw_start);
      bus.wvalid  = w_pend && (cyc >= w_start);
      aw_hs = bus.awvalid && bus.awready;
      w_hs  = bus.wvalid && bus.wready;
      tick();
      if (aw_hs) aw_pend = 1'b0;
      if (w_hs)  w_pend  = 1'b0;
      cyc++;
      if (!w_pend && aw_pend)  check("wready_after_w", bus.wready, 1'b0);
      if (!aw_pend && w_pend)  check("awready_after_aw", bus.awready, 1'b0);
    end
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    check("aw_w_handshake", {aw_pend, w_pend}, 2'b00);
    while (!bus.bvalid && n < 40) begin
      tick();
      n++;
    end
    check("b_latency", n, LAT + 1);
    exp_resp = !in_rng(a) ? 2'b11 : (len != 8'd0) ? 2'b10 : 2'b00;
    check("bresp", bus.bresp, exp_resp);
    check("bid", bus.bid, id);
    if (exp_resp == 2'b00) begin
      w = (longint'({32'h0, a}) - BASE_L) / 8;
      word = ref_word(a);
      for (int i = 0; i < 8; i++) if (s[i]) word[8*i +: 8] = d[8*i +: 8];
      ref_mem[w] = word;
    end
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    check("bvalid_drop", bus.bvalid, 1'b0);
    check("awready_back", bus.awready, 1'b1);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [3:0] id, input int unsigned hold,
                         output logic [63:0] d0, output logic [1:0] r0);
    int unsigned n;
    logic [31:0] ba;
    logic [63:0] exp_d;
    logic [1:0]  exp_r;
    d0 = '0;
    r0 = '0;
    bus.araddr = a; bus.arid = id; bus.arlen = len; bus.arsize = size; bus.arburst = burst;
    bus.arvalid = 1'b1;
    n = 0;
    while (!bus.arready && n < 40) begin
      tick();
      n++;
    end
    check("arready_idle", bus.arready, 1'b1);
    tick();
    bus.arvalid = 1'b0;
    check("arready_busy", bus.arready, 1'b0);
    for (int k = 0; k <= int'(len); k++) begin
      ba = (burst == 2'b01) ? a + 32'(k * (1 << size)) : a;
      exp_d = ref_word(ba);
      exp_r = in_rng(ba) ? 2'b00 : 2'b11;
      n = 0;
      while (!bus.rvalid && n < 40) begin
        tick();
        n++;
      end
      check("r_latency", n, LAT + 1);
      check("rdata", bus.rdata, exp_d);
      check("rresp", bus.rresp, exp_r);
      check("rid", bus.rid, id);
      check("rlast", bus.rlast, (k == int'(len)));
      if (k == 0) begin
        d0 = bus.rdata;
        r0 = bus.rresp;
      end
      for (int unsigned h = 0; h < hold; h++) begin
        tick();
        check("rvalid_held", bus.rvalid, 1'b1);
        check("rdata_held", bus.rdata, exp_d);
      end
      bus.rready = 1'b1;
      tick();
      bus.rready = 1'b0;
    end
    check("arready_after_burst", bus.arready, 1'b1);
  endtask

  initial begin
    logic [63:0] d0, old;
    logic [1:0]  r0;
    logic [31:0] a;
    logic [31:0] edges [4];
    bus.araddr = '0; bus.arid = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
    bus.arvalid = 1'b0; bus.rready = 1'b0;
    bus.awaddr = '0; bus.awid = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
    bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b0;

    repeat (3) tick();
    check("rst_rvalid", bus.rvalid, 1'b0);
    check("rst_bvalid", bus.bvalid, 1'b0);
    check("rst_rdata", bus.rdata, 64'h0);
    check("rst_rlast", bus.rlast, 1'b0);
    check("rst_bresp", bus.bresp, 2'b00);
    check("rst_arready_in_reset", bus.arready, 1'b0);
    rst = 1'b0;
    tick();
    check("arready_after_rst", bus.arready, 1'b1);
    check("awready_after_rst", bus.awready, 1'b1);

    for (int i = 0; i < 16; i++)
      do_write(32'h8000_0000 + 32'(i * 8), {$urandom, $urandom}, 8'hFF, 8'd0, 4'(i), 0, 0);
    do_write(32'h8000_7FF8, {$urandom, $urandom}, 8'hFF, 8'd0, 4'd7, 1, 0);

    // Full-word write then readback, first beat at T+3.
    do_write(32'h8000_0010, 64'h1122334455667788, 8'hFF, 8'd0, 4'd3, 0, 0);
    do_read(32'h8000_0010, 8'd0, 3'd3, 2'b01, 4'd5, 0, d0, r0);
    check("t1_readback", d0, 64'h1122334455667788);

    do_write(32'h8000_0010, 64'hFFFFFFFF_AAAAAAAA, 8'h0F, 8'd0, 4'd9, 0, 0);
    do_read(32'h8000_0010, 8'd0, 3'd3, 2'b01, 4'd1, 0, d0, r0);
    check("t2_partial", d0, 64'h11223344AAAAAAAA);

    // W leads AW by three cycles.
    do_write(32'h8000_0018, 64'hDEADBEEF_01234567, 8'hFF, 8'd0, 4'd12, 0, 3);
    do_read(32'h8000_0018, 8'd0, 3'd3, 2'b01, 4'd2, 0, d0, r0);
    check("t3_readback", d0, 64'hDEADBEEF_01234567);

    do_read(32'h8000_0000, 8'd3, 3'd3, 2'b01, 4'd6, 1, d0, r0);

    do_read(32'h0000_0000, 8'd0, 3'd3, 2'b01, 4'd4, 0, d0, r0);
    check("t5_oob_rresp", r0, 2'b11);
    check("t5_oob_rdata", d0, 64'h0);
    do_write(32'h8000_0010, 64'h0, 8'hFF, 8'd1, 4'd8, 0, 0);
    do_read(32'h8000_0010, 8'd0, 3'd3, 2'b01, 4'd1, 0, d0, r0);
    check("t5_awlen_unchanged", d0, 64'h11223344AAAAAAAA);

    // Reset while both channels are waiting on latency.
    old = ref_word(32'h8000_0020);
    bus.araddr = 32'h8000_0020; bus.arid = 4'd3; bus.arlen = 8'd0; bus.arsize = 3'd3;
    bus.arburst = 2'b01; bus.arvalid = 1'b1;
    bus.awaddr = 32'h8000_0020; bus.awid = 4'd2; bus.awlen = 8'd0;
    bus.wdata = ~old; bus.wstrb = 8'hFF; bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    tick();
    bus.arvalid = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    rst = 1'b1;
    tick();
    check("t6_arready_in_rst", bus.arready, 1'b0);
    rst = 1'b0;
    #1;
    check("t6_arready", bus.arready, 1'b1);
    check("t6_awready", bus.awready, 1'b1);
    check("t6_wready", bus.wready, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("t6_rvalid_quiet", bus.rvalid, 1'b0);
      check("t6_bvalid_quiet", bus.bvalid, 1'b0);
      tick();
    end
    do_read(32'h8000_0020, 8'd0, 3'd3, 2'b01, 4'd0, 0, d0, r0);
    check("t6_mem_unchanged", d0, old);

    edges[0] = 32'h0000_0000;
    edges[1] = 32'h7FFF_FFF8;
    edges[2] = 32'h8000_8000;
    edges[3] = 32'h8000_7FF8;
    for (int op = 0; op < 40; op++) begin
      if ($urandom_range(0, 4) == 0) a = edges[$urandom_range(0, 3)];
      else a = 32'h8000_0000 + 32'($urandom_range(0, 8) * 8) + 32'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0)
        do_write(a, {$urandom, $urandom}, 8'($urandom), ($urandom_range(0, 5) == 0) ? 8'd1 : 8'd0,
                 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
      else
        do_read(a, 8'($urandom_range(0, 5)), 3'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                4'($urandom), $urandom_range(0, 2), d0, r0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
